pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32 pipeline.
- Drives stall enables and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and drives the EX-stage forwarding mux selects.
- Adds a data-memory wait FSM with timeout for variable-latency dmem, plus a saturating stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM_WAIT before abort (≥2)
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
rs1d  in  5  rs1 of instruction in D
rs2d  in  5  rs2 of instruction in D
rs1e  in  5  rs1 in E
rs2e  in  5  rs2 in E
rde  in  5  rd in E
resultsrce  in  2  result select in E; 2'b01 = load
rdm  in  5  rd in M
regwritem  in  1  M writes register file
rdw  in  5  rd in W
regwritew  in  1  W writes register file
pcsrce  in  1  taken branch/jump resolved in E
memreq_m  in  1  M holds a load/store
dmem_ack  in  1  dmem completes M access this cycle
cnt_clr  in  1  clear stall_cnt
stallf  out  1  hold PC
stalld  out  1  hold IF/ID
stalle  out  1  hold ID/EX
stallm  out  1  hold EX/MEM
flushd  out  1  clear IF/ID
flushe  out  1  clear ID/EX (its clr input)
flushw  out  1  clear MEM/WB
forwardae  out  2  ALU A select: 00 reg, 01 W result, 10 M ALU result
forwardbe  out  2  ALU B select, same encoding
mem_err  out  1  one-cycle pulse on dmem timeout
stall_cnt  out  CNT_W  saturating count of cycles with stallf=1

Behaviour:
- Registered state: FSM {RUN, MEM_WAIT}, wait_cnt, mem_err, stall_cnt.
- All other outputs are combinational from the registered state and the current inputs. Zero latency.
- Forwarding (A; B identical using rs2e):
  - 10 if regwritem && rdm!=0 && rdm==rs1e.
  - Otherwise 01 if regwritew && rdw!=0 && rdw==rs1e.
  - Otherwise 00.
  - M has priority over W.
- lwstall = (resultsrce==2'b01) && rde!=0 && (rde==rs1d || rde==rs2d).
- memstall = (RUN && memreq_m && !dmem_ack) || (MEM_WAIT && !dmem_ack && wait_cnt!=MEM_TIMEOUT-1).
- memstall=1 has highest priority:
  - stallf=stalld=stalle=stallm=1, flushw=1.
  - flushd=flushe=0; pcsrce is ignored because E is frozen, and it re-applies after release.
- Otherwise:
  - stallf=stalld=lwstall.
  - flushe=lwstall|pcsrce; flushd=pcsrce.
  - stalle=stallm=0; flushw=0.
  - If load-use and pcsrce coincide, both actions apply.
- FSM transitions:
  - RUN: memreq_m && !dmem_ack -> MEM_WAIT, wait_cnt<=1. memreq_m && dmem_ack -> stay RUN, no stall.
  - MEM_WAIT, dmem_ack=1 -> RUN, wait_cnt<=0. Stalls deasserted in the ack cycle so the pipeline advances.
  - MEM_WAIT, no ack, wait_cnt==MEM_TIMEOUT-1 -> RUN. mem_err<=1 for the next cycle only. Stalls released this cycle with flushw=1 so the aborted result is dropped.
  - MEM_WAIT, otherwise: wait_cnt<=wait_cnt+1.
  - Total stall cycles with no ack = MEM_TIMEOUT-1.
- stall_cnt:
  - cnt_clr -> 0 (cnt_clr has priority over increment).
  - Else, if stallf=1 and stall_cnt != all-ones, increment by 1.
  - Saturates at 2^CNT_W-1.
- Reset (rst=1 at a clock edge):
  - state<=RUN, wait_cnt<=0, mem_err<=0, stall_cnt<=0. Applies mid-MEM_WAIT too; no mem_err is generated.
  - While rst=1, combinational outputs are forced: stall*=0, flushd=flushe=flushw=1, forward*=00.

Test Plan:
- rdm=rdw=rs1e=5, regwritem=regwritew=1 -> forwardae=10. Then regwritem=0 -> 01. Then rdm=rdw=rs1e=0 -> 00.
- resultsrce=01, rde=7, rs2d=7, no memreq -> stallf=stalld=flushe=1, flushd=0 for exactly that cycle. Set rde=0 -> no stall.
- pcsrce=1 with lwstall=1 -> flushd=flushe=stallf=stalld=1. Then pcsrce alone -> flushd=flushe=1, stallf=0.
- memreq_m=1, ack on the 3rd cycle:
  - stall*=1 and flushw=1 for 2 cycles; stalls released in the ack cycle.
  - Returns to RUN; stall_cnt increments by 2; pcsrce=1 during the wait has no flush effect.
- MEM_TIMEOUT=4, memreq_m=1, never ack:
  - Stalls for 3 cycles, then release with flushw=1.
  - mem_err high for exactly 1 cycle; FSM back in RUN.
- Assert rst on the 2nd MEM_WAIT cycle -> next cycle RUN, stall_cnt=0, mem_err=0. While rst is high, flushd=flushe=flushw=1 and stalls are 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pipeline_ctrl_if : hazard-unit pipeline signal bundle   rev 1.0
// ------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1d;
  logic [4:0]       rs2d;
  logic [4:0]       rs1e;
  logic [4:0]       rs2e;
  logic [4:0]       rde;
  logic [1:0]       resultsrce;
  logic [4:0]       rdm;
  logic             regwritem;
  logic [4:0]       rdw;
  logic             regwritew;
  logic             pcsrce;
  logic             memreq_m;
  logic             dmem_ack;
  logic             cnt_clr;
  logic             stallf;
  logic             stalld;
  logic             stalle;
  logic             stallm;
  logic             flushd;
  logic             flushe;
  logic             flushw;
  logic [1:0]       forwardae;
  logic [1:0]       forwardbe;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1d, rs2d, rs1e, rs2e, rde, resultsrce, rdm, regwritem,
           rdw, regwritew, pcsrce, memreq_m, dmem_ack, cnt_clr,
    input  stallf, stalld, stalle, stallm, flushd, flushe, flushw,
           forwardae, forwardbe, mem_err, stall_cnt
  );

  modport slave (
    input  rs1d, rs2d, rs1e, rs2e, rde, resultsrce, rdm, regwritem,
           rdw, regwritew, pcsrce, memreq_m, dmem_ack, cnt_clr,
    output stallf, stalld, stalle, stallm, flushd, flushe, flushw,
           forwardae, forwardbe, mem_err, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// pipeline_ctrl : RV32 hazard, forwarding and dmem-wait control  rev 1.0
// ------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_ctrl_if.slave      bus
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       lwstall;
  logic       memstall;
  logic       timeout;
  logic       stallf;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       regwritem,
    input logic [4:0] rdw,
    input logic       regwritew
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (regwritem && (rdm != 5'd0) && (rdm == rs))
      sel = 2'b10;
    else if (regwritew && (rdw != 5'd0) && (rdw == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign fwd_a = fwd_sel(bus.rs1e, bus.rdm, bus.regwritem, bus.rdw, bus.regwritew);
  assign fwd_b = fwd_sel(bus.rs2e, bus.rdm, bus.regwritem, bus.rdw, bus.regwritew);

  assign lwstall = (bus.resultsrce == 2'b01) && (bus.rde != 5'd0) &&
                   ((bus.rde == bus.rs1d) || (bus.rde == bus.rs2d));

  assign memstall = ((state_q == ST_RUN) && bus.memreq_m && !bus.dmem_ack) ||
                    ((state_q == ST_MEM_WAIT) && !bus.dmem_ack && (wait_cnt_q != WAIT_LAST));

  assign timeout = (state_q == ST_MEM_WAIT) && !bus.dmem_ack && (wait_cnt_q == WAIT_LAST);

  // E is frozen during a memory stall, so a resolved branch waits until release.
  always_comb begin
    stallf        = 1'b0;
    bus.stalld    = 1'b0;
    bus.stalle    = 1'b0;
    bus.stallm    = 1'b0;
    bus.flushd    = 1'b0;
    bus.flushe    = 1'b0;
    bus.flushw    = 1'b0;
    bus.forwardae = 2'b00;
    bus.forwardbe = 2'b00;
    if (rst) begin
      bus.flushd = 1'b1;
      bus.flushe = 1'b1;
      bus.flushw = 1'b1;
    end else begin
      bus.forwardae = fwd_a;
      bus.forwardbe = fwd_b;
      if (memstall) begin
        stallf     = 1'b1;
        bus.stalld = 1'b1;
        bus.stalle = 1'b1;
        bus.stallm = 1'b1;
        bus.flushw = 1'b1;
      end else begin
        stallf     = lwstall;
        bus.stalld = lwstall;
        bus.flushe = lwstall | bus.pcsrce;
        bus.flushd = bus.pcsrce;
        bus.flushw = timeout;
      end
    end
  end

  assign bus.stallf    = stallf;
  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.memreq_m && !bus.dmem_ack) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.cnt_clr)
      stall_cnt_d = '0;
    else if (stallf && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pipeline_ctrl : directed + random check against a reference model  rev 1.0
// ------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int T    = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: whether an access is outstanding and how many stall cycles it has cost.
  bit m_pending = 0;
  int m_spent   = 0;
  bit m_err     = 0;
  int m_cnt     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (bus.regwritem && bus.rdm != 0 && bus.rdm == rs) return 2'b10;
    if (bus.regwritew && bus.rdw != 0 && bus.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_in();
    bus.rs1d = 0; bus.rs2d = 0; bus.rs1e = 0; bus.rs2e = 0; bus.rde = 0;
    bus.resultsrce = 0; bus.rdm = 0; bus.regwritem = 0; bus.rdw = 0;
    bus.regwritew = 0; bus.pcsrce = 0; bus.memreq_m = 0; bus.dmem_ack = 0;
    bus.cnt_clr = 0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    bit lw, ms, to, e_stall, e_fd, e_fe, e_fw;
    logic [1:0] e_fa, e_fb;
    #1;
    lw = (bus.resultsrce == 2'b01) && bus.rde != 0 &&
         (bus.rde == bus.rs1d || bus.rde == bus.rs2d);
    ms = !bus.dmem_ack && (m_pending || bus.memreq_m) && (m_spent < T - 1);
    to = m_pending && !bus.dmem_ack && (m_spent == T - 1);
    if (rst) begin
      e_stall = 0; e_fd = 1; e_fe = 1; e_fw = 1; e_fa = 0; e_fb = 0;
    end else begin
      e_fa = ref_fwd(bus.rs1e);
      e_fb = ref_fwd(bus.rs2e);
      if (ms) begin
        e_stall = 1; e_fd = 0; e_fe = 0; e_fw = 1;
      end else begin
        e_stall = lw; e_fd = bus.pcsrce; e_fe = lw | bus.pcsrce; e_fw = to;
      end
    end
    chk("stallf",    32'(bus.stallf),    32'(e_stall));
    chk("stalld",    32'(bus.stalld),    32'(e_stall));
    chk("stalle",    32'(bus.stalle),    32'(!rst && ms));
    chk("stallm",    32'(bus.stallm),    32'(!rst && ms));
    chk("flushd",    32'(bus.flushd),    32'(e_fd));
    chk("flushe",    32'(bus.flushe),    32'(e_fe));
    chk("flushw",    32'(bus.flushw),    32'(e_fw));
    chk("forwardae", 32'(bus.forwardae), 32'(e_fa));
    chk("forwardbe", 32'(bus.forwardbe), 32'(e_fb));
    chk("mem_err",   32'(bus.mem_err),   32'(m_err));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      m_pending = 0; m_spent = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_err = to;
      if (bus.cnt_clr)                  m_cnt = 0;
      else if (e_stall && m_cnt < CMAX) m_cnt = m_cnt + 1;
      if (ms) begin
        m_pending = 1; m_spent = m_spent + 1;
      end else begin
        m_pending = 0; m_spent = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Forwarding priority.
    bus.rdm = 5; bus.rdw = 5; bus.rs1e = 5; bus.regwritem = 1; bus.regwritew = 1;
    #1 chk("tp_fwd_m", 32'(bus.forwardae), 32'h2);
    tick();
    bus.regwritem = 0;
    #1 chk("tp_fwd_w", 32'(bus.forwardae), 32'h1);
    tick();
    bus.rdm = 0; bus.rdw = 0; bus.rs1e = 0;
    #1 chk("tp_fwd_0", 32'(bus.forwardae), 32'h0);
    tick();

    // Load-use, then with a coincident taken branch.
    clear_in();
    bus.resultsrce = 2'b01; bus.rde = 7; bus.rs2d = 7;
    #1 chk("tp_lw_stall", 32'(bus.stallf), 32'h1);
    tick();
    bus.pcsrce = 1;
    #1 chk("tp_lw_br_fd", 32'(bus.flushd), 32'h1);
    tick();
    bus.rde = 0;
    #1 chk("tp_br_nostall", 32'(bus.stallf), 32'h0);
    tick();

    // dmem ack on the third cycle, branch during the wait is ignored.
    clear_in();
    bus.memreq_m = 1;
    tick();
    bus.pcsrce = 1;
    #1 chk("tp_wait_nofd", 32'(bus.flushd), 32'h0);
    tick();
    bus.pcsrce = 0; bus.dmem_ack = 1;
    #1 chk("tp_ack_release", 32'(bus.stallf), 32'h0);
    tick();
    clear_in();
    tick();

    // Timeout: never ack.
    bus.memreq_m = 1;
    tick(); tick(); tick();
    #1 chk("tp_to_flushw", 32'(bus.flushw), 32'h1);
    tick();
    bus.memreq_m = 0;
    #1 chk("tp_to_err", 32'(bus.mem_err), 32'h1);
    tick();
    tick();

    // Reset in the middle of a wait.
    bus.memreq_m = 1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.memreq_m = 0;
    #1 chk("tp_rst_cnt", 32'(bus.stall_cnt), 32'h0);
    tick();

    // Random traffic with small register numbers for frequent hazards.
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 59) == 0);
      bus.rs1d       = 5'($urandom_range(0, 3));
      bus.rs2d       = 5'($urandom_range(0, 3));
      bus.rs1e       = 5'($urandom_range(0, 3));
      bus.rs2e       = 5'($urandom_range(0, 3));
      bus.rde        = 5'($urandom_range(0, 3));
      bus.rdm        = 5'($urandom_range(0, 3));
      bus.rdw        = 5'($urandom_range(0, 3));
      bus.resultsrce = 2'($urandom_range(0, 3));
      bus.regwritem  = 1'($urandom_range(0, 1));
      bus.regwritew  = 1'($urandom_range(0, 1));
      bus.pcsrce     = ($urandom_range(0, 3) == 0);
      bus.memreq_m   = ($urandom_range(0, 2) == 0);
      bus.dmem_ack   = ($urandom_range(0, 2) == 0);
      bus.cnt_clr    = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
